dmem_unit: RTL and testbench



---
 rtl/dmem_unit_pkg.sv | 34 +++
 rtl/dmem_bytes.sv | 33 +++
 rtl/dmem_unit.sv | 160 ++++++++++++++++
 tb/tb_dmem_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_unit_pkg.sv
// Shared definitions for the data-memory unit: access size codes, RISC-V
// exception cause codes and FSM state encodings.
package dmem_unit_pkg;

    localparam logic [1:0] W_B = 2'b00;
    localparam logic [1:0] W_H = 2'b01;
    localparam logic [1:0] W_W = 2'b10;

    localparam logic [3:0] EXC_NONE        = 4'd0;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Offset of the last byte touched by an access of the given size.
    // The reserved code maps to a word so its range check stays conservative.
    function automatic logic [1:0] size_last(input logic [1:0] op);
        logic [1:0] last;
        case (op)
            W_B:     last = 2'd0;
            W_H:     last = 2'd1;
            W_W:     last = 2'd3;
            default: last = 2'd3;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/dmem_bytes.sv
// Little-endian byte array with a 4-lane write port (per-lane byte enable and
// address) and a 4-lane asynchronous read. Contents are never reset.
module dmem_bytes
    import dmem_unit_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                       clk,
    input  logic [3:0]                 we,
    input  logic [3:0][DEPTH_LOG2-1:0] adr,
    input  logic [3:0][7:0]            wdata,
    output logic [3:0][7:0]            rdata
);

    logic [7:0] mem_r [0:(1<<DEPTH_LOG2)-1];

    // Byte-lane writes; lanes always address distinct bytes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_r[adr[i]] <= wdata[i];
            end
        end
    end

    // Byte-lane reads.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata[i] = mem_r[adr[i]];
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// MEM-stage data memory with valid/ready handshake, wait states, load
// extension and exception reporting. Define DMEM_MISALIGN_EXC_EN to trap
// misaligned half/word accesses instead of completing them byte-wise.
module dmem_unit
    import dmem_unit_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic        req_unsigned,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [3:0]  rsp_exc_code
);

    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                     state_r;
    state_t                     next_state_s;
    logic [3:0]                 wait_cnt_r;
    logic                       accept_s;
    logic [1:0]                 last_off_s;
    logic [32:0]                last_adr_s;
    logic                       fault_s;
    logic                       misalign_s;
    logic                       exc_s;
    logic [3:0]                 code_s;
    logic [3:0]                 lane_en_s;
    logic [3:0]                 wr_en_s;
    logic [3:0][DEPTH_LOG2-1:0] lane_adr_s;
    logic [3:0][7:0]            lane_wdata_s;
    logic [3:0][7:0]            lane_rdata_s;
    logic [31:0]                ld_data_s;
    logic [31:0]                rsp_data_s;

    assign accept_s = req_valid & req_ready;

    dmem_bytes #(.DEPTH_LOG2(DEPTH_LOG2)) u_bytes (
        .clk   (clk),
        .we    (wr_en_s),
        .adr   (lane_adr_s),
        .wdata (lane_wdata_s),
        .rdata (lane_rdata_s)
    );

    // Fault/misalignment classification and per-lane byte steering.
    always_comb begin
        last_off_s = size_last(req_op);
        // 33-bit sum so an access running past 2^32 is caught rather than wrapped.
        last_adr_s = {1'b0, req_adr} + {31'b0, last_off_s};
        fault_s    = (req_op == 2'b11) || ((last_adr_s >> DEPTH_LOG2) != 33'd0);
`ifdef DMEM_MISALIGN_EXC_EN
        misalign_s = ((req_op == W_H) && req_adr[0]) ||
                     ((req_op == W_W) && (req_adr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        exc_s = misalign_s | fault_s;
        if (!exc_s) begin
            code_s = EXC_NONE;
        end else if (misalign_s) begin
            code_s = req_we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end else begin
            code_s = req_we ? EXC_ST_FAULT : EXC_LD_FAULT;
        end
        for (int i = 0; i < 4; i++) begin
            lane_en_s[i]    = (2'(i) <= last_off_s);
            lane_adr_s[i]   = req_adr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(i);
            lane_wdata_s[i] = req_wdata[8*i +: 8];
        end
        if (accept_s && req_we && !exc_s) begin
            wr_en_s = lane_en_s;
        end else begin
            wr_en_s = 4'b0000;
        end
    end

    // Load extension and response data selection.
    always_comb begin
        case (req_op)
            W_B:     ld_data_s = {{24{lane_rdata_s[0][7] & ~req_unsigned}}, lane_rdata_s[0]};
            W_H:     ld_data_s = {{16{lane_rdata_s[1][7] & ~req_unsigned}}, lane_rdata_s[1], lane_rdata_s[0]};
            W_W:     ld_data_s = lane_rdata_s;
            default: ld_data_s = 32'h0000_0000;
        endcase
        if (exc_s || req_we) begin
            rsp_data_s = 32'h0000_0000;
        end else begin
            rsp_data_s = ld_data_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, wait counter and registered handshake/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 4'd0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0000_0000;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= 4'd0;
        end else begin
            state_r   <= next_state_s;
            req_ready <= (next_state_s == ST_IDLE);
            rsp_valid <= (next_state_s == ST_RESP);
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
            // Response fields load only at accept, so they hold while stalled.
            if (accept_s) begin
                rsp_rdata    <= rsp_data_s;
                rsp_exc      <= exc_s;
                rsp_exc_code <= code_s;
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Table-driven self-checking bench for dmem_unit (DEPTH_LOG2=10, WAIT_STATES=3).
// Expectations follow DMEM_MISALIGN_EXC_EN when it is defined.
module tb_dmem_unit;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_op;
    logic        req_unsigned;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [3:0]  rsp_exc_code;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_unit #(.DEPTH_LOG2(10), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_op       (req_op),
        .req_unsigned (req_unsigned),
        .req_adr      (req_adr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_exc      (rsp_exc),
        .rsp_exc_code (rsp_exc_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic        uns;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_exc;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] op, input logic uns,
                                input logic [31:0] adr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_exc,
                                input logic [3:0] exp_code);
        vec_t v;
        v.we = we; v.op = op; v.uns = uns; v.adr = adr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_exc = exp_exc; v.exp_code = exp_code;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; hold = cycles to stall the response.
    task automatic do_access(input logic we, input logic [1:0] op, input logic uns,
                             input logic [31:0] adr, input logic [31:0] wd, input int hold,
                             output logic [31:0] rd, output logic ex, output logic [3:0] code,
                             output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        req_we = we; req_op = op; req_unsigned = uns; req_adr = adr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hxxxx_xxxx;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata; ex = rsp_exc; code = rsp_exc_code;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_rdata", rsp_rdata, rd);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ex;
        logic [3:0]  code;
        int          lat;
        logic        mis;

`ifdef DMEM_MISALIGN_EXC_EN
        mis = 1'b1;
`else
        mis = 1'b0;
`endif
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 2'b00;
        req_unsigned = 1'b0; req_adr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_exc", {31'b0, rsp_exc}, 32'd0);
        chk("rst_code", {28'b0, rsp_exc_code}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'b0, req_ready}, 32'd1);

        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h8765_4321, 32'h0, 0, 4'd0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h10, 32'h0, 32'h0000_0021, 0, 4'd0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFF_FF87, 0, 4'd0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 32'h0000_0087, 0, 4'd0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_8765, 0, 4'd0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h10, 32'h0, 32'h0000_4321, 0, 4'd0));
        vecs.push_back(mk(0, 2'b10, 1, 32'h10, 32'h0, 32'h8765_4321, 0, 4'd0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h20, 32'hDDCC_BBAA, 32'h0, 0, 4'd0));
        if (mis) begin
            vecs.push_back(mk(1, 2'b01, 0, 32'h21, 32'h0000_1234, 32'h0, 1, 4'd6));
            vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hDDCC_BBAA, 0, 4'd0));
        end else begin
            vecs.push_back(mk(1, 2'b01, 0, 32'h21, 32'h0000_1234, 32'h0, 0, 4'd0));
            vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hDD12_34AA, 0, 4'd0));
        end
        vecs.push_back(mk(1, 2'b10, 0, 32'h14, 32'h0000_0099, 32'h0, 0, 4'd0));
        if (mis) begin
            vecs.push_back(mk(0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, 4'd4));
            vecs.push_back(mk(0, 2'b10, 0, 32'h3FE, 32'h0, 32'h0, 1, 4'd4));
        end else begin
            vecs.push_back(mk(0, 2'b10, 0, 32'h11, 32'h0, 32'h9987_6543, 0, 4'd0));
            vecs.push_back(mk(0, 2'b10, 0, 32'h3FE, 32'h0, 32'h0, 1, 4'd5));
        end
        vecs.push_back(mk(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1, 4'd5));
        vecs.push_back(mk(1, 2'b00, 0, 32'h3FF, 32'h0000_005A, 32'h0, 0, 4'd0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h3FF, 32'h0, 32'h0000_005A, 0, 4'd0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h3FF, 32'h0, 32'h0000_005A, 0, 4'd0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0, 32'h1122_3344, 32'h0, 0, 4'd0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1, 4'd7));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0, 32'h0, 32'h1122_3344, 0, 4'd0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3FF, 32'h0, 32'h0, 1, mis ? 4'd4 : 4'd5));
        vecs.push_back(mk(0, 2'b01, 1, 32'h3FF, 32'h0, 32'h0, 1, mis ? 4'd4 : 4'd5));
        vecs.push_back(mk(1, 2'b01, 0, 32'hFFFF_FFFE, 32'h0000_5555, 32'h0, 1, 4'd7));
        vecs.push_back(mk(0, 2'b00, 0, 32'h8000_0010, 32'h0, 32'h0, 1, 4'd5));
        vecs.push_back(mk(1, 2'b01, 0, 32'h3FE, 32'h0000_BEEF, 32'h0, 0, 4'd0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h3FE, 32'h0, 32'hFFFF_BEEF, 0, 4'd0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 4'd5));

        foreach (vecs[i]) begin
            do_access(vecs[i].we, vecs[i].op, vecs[i].uns, vecs[i].adr, vecs[i].wdata, 0,
                      rd, ex, code, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_exc", i), {31'b0, ex}, {31'b0, vecs[i].exp_exc});
            chk($sformatf("v%0d_code", i), {28'b0, code}, {28'b0, vecs[i].exp_code});
            chk($sformatf("v%0d_latency", i), lat, 1 + WS);
        end

        // Stalled response: outputs hold and no new request is accepted.
        do_access(0, 2'b10, 0, 32'h10, 32'h0, 5, rd, ex, code, lat);
        chk("stall_rdata", rd, 32'h8765_4321);
        chk("stall_latency", lat, 1 + WS);
        chk("after_stall_ready", {31'b0, req_ready}, 32'd1);

        // Reset while a load waits: response dropped, memory kept.
        do_access(1, 2'b10, 0, 32'h40, 32'hCAFE_F00D, 0, rd, ex, code, lat);
        req_we = 1'b0; req_op = 2'b10; req_unsigned = 1'b0; req_adr = 32'h40;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("in_wait_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_exc", {31'b0, rsp_exc}, 32'd0);
        chk("mid_rst_code", {28'b0, rsp_exc_code}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("in_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        do_access(0, 2'b10, 0, 32'h40, 32'h0, 0, rd, ex, code, lat);
        chk("post_rst_load", rd, 32'hCAFE_F00D);
        chk("post_rst_exc", {31'b0, ex}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
